transport_rcv: RTL

TRANSPORT_RCV -- requirements
Module: transport_rcv

---
 rtl/transport_rcv.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/transport_rcv.sv
// rtl/transport_rcv.sv - framed byte receiver with checksum check and payload word buffer
module transport_rcv #(
    parameter int MAX_WORDS = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rcvByte,
    input  logic [7:0]  packetIn,
    input  logic        readData,
    output logic [1:0]  cmd,
    output logic        cmdValid,
    output logic [15:0] data,
    output logic        dataReady,
    output logic        frameError,
    output logic        busy
);

    // Index width addresses the buffer; pointers carry one extra bit so a
    // full buffer (count == MAX_WORDS) is representable without wrapping.
    localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int AW = IW + 1;
    // The gap counter only has to reach TIMEOUT-1: the TIMEOUT-th idle cycle
    // is detected while the counter holds TIMEOUT-1.
    localparam int GW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);
    localparam logic [AW-1:0] PTR_LIMIT = AW'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        MSB,
        LSB,
        CHK,
        DRAIN
    } state_t;

    state_t          state;
    logic [15:0]     mem [0:MAX_WORDS-1];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   count;
    logic [AW-1:0]   rd_next;
    logic [5:0]      words_left;
    logic [7:0]      hi_byte;
    logic [7:0]      csum;
    logic [1:0]      hdr_cmd;
    logic [GW-1:0]   gap;
    logic            wr_en;

    assign busy    = (state != IDLE);
    assign rd_next = rd_ptr + AW'(1);
    // The pointer bound is redundant with the header size check, but keeps a
    // corrupted pointer from ever writing outside the array.
    assign wr_en   = (state == LSB) && rcvByte && !reset && (wr_ptr < PTR_LIMIT);

    // Payload storage: one word written per completed MSB/LSB byte pair.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[IW-1:0]] <= {hi_byte, packetIn};
        end
    end

    // Frame parser, gap watchdog, buffer bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd        <= 2'b00;
            cmdValid   <= 1'b0;
            data       <= 16'h0000;
            dataReady  <= 1'b0;
            frameError <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            words_left <= 6'd0;
            hi_byte    <= 8'h00;
            csum       <= 8'h00;
            hdr_cmd    <= 2'b00;
            gap        <= '0;
        end else begin
            cmdValid   <= 1'b0;
            frameError <= 1'b0;

            case (state)
                IDLE: begin
                    gap <= '0;
                    if (rcvByte) begin
                        if (packetIn[7:6] == 2'b00) begin
                            // cmd 00 is line filler between frames
                        end else if (int'(packetIn[5:0]) > MAX_WORDS) begin
                            frameError <= 1'b1;
                        end else begin
                            hdr_cmd    <= packetIn[7:6];
                            words_left <= packetIn[5:0];
                            csum       <= packetIn;
                            state      <= (packetIn[5:0] == 6'd0) ? CHK : MSB;
                        end
                    end
                end

                MSB, LSB, CHK: begin
                    if (rcvByte) begin
                        gap <= '0;
                        if (state == MSB) begin
                            hi_byte <= packetIn;
                            csum    <= csum ^ packetIn;
                            state   <= LSB;
                        end else if (state == LSB) begin
                            wr_ptr     <= wr_ptr + AW'(1);
                            count      <= count + AW'(1);
                            csum       <= csum ^ packetIn;
                            words_left <= words_left - 6'd1;
                            state      <= (words_left == 6'd1) ? CHK : MSB;
                        end else if (packetIn == csum) begin
                            cmd      <= hdr_cmd;
                            cmdValid <= 1'b1;
                            if (count != '0) begin
                                dataReady <= 1'b1;
                                data      <= mem[rd_ptr[IW-1:0]];
                                state     <= DRAIN;
                            end else begin
                                wr_ptr <= '0;
                                rd_ptr <= '0;
                                state  <= IDLE;
                            end
                        end else begin
                            // Bad checksum: discard the whole frame, keep cmd.
                            frameError <= 1'b1;
                            wr_ptr     <= '0;
                            rd_ptr     <= '0;
                            count      <= '0;
                            state      <= IDLE;
                        end
                    end else if (gap == GAP_LAST) begin
                        // Sender stalled mid-frame: abandon it.
                        frameError <= 1'b1;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        count      <= '0;
                        gap        <= '0;
                        state      <= IDLE;
                    end else begin
                        gap <= gap + GW'(1);
                    end
                end

                DRAIN: begin
                    gap <= '0;
                    // No room for a new frame until the reader empties the
                    // buffer, so incoming bytes are dropped and flagged.
                    if (rcvByte) begin
                        frameError <= 1'b1;
                    end
                    if (readData && dataReady) begin
                        if (count == AW'(1)) begin
                            dataReady <= 1'b0;
                            data      <= 16'h0000;
                            wr_ptr    <= '0;
                            rd_ptr    <= '0;
                            count     <= '0;
                            state     <= IDLE;
                        end else begin
                            rd_ptr <= rd_next;
                            count  <= count - AW'(1);
                            data   <= (rd_next < PTR_LIMIT) ? mem[rd_next[IW-1:0]] : 16'h0000;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
